// File: rtl/j_ext_pkg.sv
// j_ext_pkg: shared FSM encoding, access-width codes and address helpers for j_extreq.
package j_ext_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StWait  = 2'd2
  } state_e;

  localparam logic [2:0] W_BYTE = 3'b000;
  localparam logic [2:0] W_WORD = 3'b010;
  localparam logic [2:0] W_LONG = 3'b100;

  localparam int unsigned AddrW   = 24;
  localparam int unsigned DataW   = 32;
  // Posted-write entry layout: {addr, w, data}
  localparam int unsigned WEntryW = AddrW + 3 + DataW;

  // Reserved width codes are treated as long accesses.
  function automatic logic [2:0] norm_w(input logic [2:0] code);
    case (code)
      W_BYTE, W_WORD: return code;
      default:        return W_LONG;
    endcase
  endfunction

  function automatic logic [23:0] align_addr(input logic [2:0] wn, input logic [23:0] a);
    case (wn)
      W_WORD:  return {a[23:1], 1'b0};
      W_LONG:  return {a[23:2], 2'b00};
      default: return a;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [2:0] wn, input logic [23:0] a);
    case (wn)
      W_WORD:  return a[0];
      W_LONG:  return |a[1:0];
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/j_ext_wfifo.sv
// j_ext_wfifo: 2-entry posted-write FIFO of {addr, w, data}; built only with JEXT_WBUF_EN.
// The head entry stays resident while its write is on the bus and is popped on completion.
`ifdef JEXT_WBUF_EN
module j_ext_wfifo
  import j_ext_pkg::*;
(
  input  logic               sys_clk,
  input  logic               resetl,
  input  logic               push,
  input  logic               pop,
  input  logic [WEntryW-1:0] wdata,
  output logic [WEntryW-1:0] rdata,
  output logic               full,
  output logic               empty
);

  logic [WEntryW-1:0] ent0_q, ent0_d, ent1_q, ent1_d;
  logic               wptr_q, wptr_d, rptr_q, rptr_d;
  logic [1:0]         cnt_q, cnt_d;
  logic               do_push, do_pop;

  assign full    = (cnt_q == 2'd2);
  assign empty   = (cnt_q == 2'd0);
  assign do_pop  = pop & ~empty;
  // A pop frees the head slot in the same cycle, so push-while-full is legal then.
  assign do_push = push & (~full | do_pop);
  assign rdata   = rptr_q ? ent1_q : ent0_q;

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    ent0_d = ent0_q;
    ent1_d = ent1_q;
    if (do_push) begin
      if (wptr_q) ent1_d = wdata;
      else        ent0_d = wdata;
    end
    wptr_d = wptr_q ^ do_push;
    rptr_d = rptr_q ^ do_pop;
    cnt_d  = cnt_q;
    if (do_push && !do_pop)      cnt_d = cnt_q + 2'd1;
    else if (do_pop && !do_push) cnt_d = cnt_q - 2'd1;
  end

  // FIFO state registers, synchronous active-low reset.
  always_ff @(posedge sys_clk) begin
    if (!resetl) begin
      ent0_q <= '0;
      ent1_q <= '0;
      wptr_q <= 1'b0;
      rptr_q <= 1'b0;
      cnt_q  <= 2'd0;
    end else begin
      ent0_q <= ent0_d;
      ent1_q <= ent1_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule
`endif

// File: rtl/j_extreq.sv
// j_extreq: sequences core load/store requests onto the external memory controller.
// Define JEXT_WBUF_EN to add a 2-entry write-posting buffer (j_ext_wfifo).
module j_extreq
  import j_ext_pkg::*;
(
  input  logic        sys_clk,
  input  logic        resetl,
  input  logic        cpu_req,
  input  logic        cpu_rw,
  input  logic [2:0]  cpu_w,
  input  logic [23:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_busy,
  output logic [31:0] cpu_rdata,
  output logic        cpu_rvalid,
  output logic        cpu_err,
  output logic        mreq,
  output logic        rw,
  output logic [2:0]  w,
  output logic [23:0] aout,
  output logic [31:0] dout,
  input  logic        ack,
  input  logic [31:0] din,
  input  logic [1:0]  dinlatch
);

  state_e      state_q, state_d;
  logic [23:0] aout_q, aout_d;
  logic [2:0]  w_q, w_d;
  logic        rw_q, rw_d;
  logic [31:0] dout_q, dout_d;
  logic [31:0] rdata_q, rdata_d;
  logic        rvalid_q, rvalid_d;
  logic        err_q, err_d;

  logic [2:0]  req_w;
  logic [23:0] req_addr;
  logic        req_mis;
  logic        idle, done;
  logic        take, load;
  logic        ld_rw;
  logic [2:0]  ld_w;
  logic [23:0] ld_addr;
  logic [31:0] ld_data;

  assign req_w    = norm_w(cpu_w);
  assign req_addr = align_addr(req_w, cpu_addr);
  assign req_mis  = is_misaligned(req_w, cpu_addr);
  assign idle     = (state_q == StIdle);
  // WAIT is entered the cycle after acceptance, so any ack seen there is completion.
  assign done     = (state_q == StWait) & ack;

`ifdef JEXT_WBUF_EN
  logic               wr_take, rd_take, fifo_pop, fifo_full, fifo_empty;
  logic [WEntryW-1:0] fifo_head;

  assign fifo_pop = done & ~rw_q;
  assign wr_take  = cpu_req & ~cpu_rw & (~fifo_full | fifo_pop);
  assign rd_take  = cpu_req & cpu_rw & idle & fifo_empty;
  assign take     = wr_take | rd_take;

  j_ext_wfifo u_wfifo (
    .sys_clk (sys_clk),
    .resetl  (resetl),
    .push    (wr_take),
    .pop     (fifo_pop),
    .wdata   ({req_addr, req_w, cpu_wdata}),
    .rdata   (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Posted writes drain first; a read only launches once the buffer is empty.
  always_comb begin
    load = idle & (~fifo_empty | rd_take);
    if (!fifo_empty) begin
      {ld_addr, ld_w, ld_data} = fifo_head;
      ld_rw = 1'b0;
    end else begin
      ld_addr = req_addr;
      ld_w    = req_w;
      ld_data = cpu_wdata;
      ld_rw   = cpu_rw;
    end
  end
`else
  assign take    = cpu_req & idle;
  assign load    = take;
  assign ld_addr = req_addr;
  assign ld_w    = req_w;
  assign ld_data = cpu_wdata;
  assign ld_rw   = cpu_rw;
`endif

  // State register.
  always_ff @(posedge sys_clk) begin
    if (!resetl) state_q <= StIdle;
    else         state_q <= state_d;
  end

  // Next-state: IDLE -> ISSUE on load, ISSUE -> WAIT on accept, WAIT -> IDLE on completion.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (load) state_d = StIssue;
      StIssue: if (ack)  state_d = StWait;
      StWait:  if (ack)  state_d = StIdle;
      default:           state_d = StIdle;
    endcase
  end

  // FSM outputs: request strobe and core back-pressure.
  always_comb begin
    mreq = (state_q == StIssue);
`ifdef JEXT_WBUF_EN
    cpu_busy = cpu_rw ? ~(idle & fifo_empty) : (fifo_full & ~fifo_pop);
`else
    cpu_busy = ~idle;
`endif
  end

  // Bus fields, read capture, load-complete pulse and sticky misalignment flag.
  always_comb begin
    aout_d  = aout_q;
    w_d     = w_q;
    rw_d    = rw_q;
    dout_d  = dout_q;
    if (load) begin
      aout_d = ld_addr;
      w_d    = ld_w;
      rw_d   = ld_rw;
      dout_d = ld_data;
    end
    rdata_d = rdata_q;
    if (dinlatch[0]) rdata_d[15:0]  = din[15:0];
    if (dinlatch[1]) rdata_d[31:16] = din[31:16];
    rvalid_d = done & rw_q;
    err_d    = err_q | (take & req_mis);
  end

  // Datapath registers, synchronous active-low reset.
  always_ff @(posedge sys_clk) begin
    if (!resetl) begin
      aout_q   <= '0;
      w_q      <= '0;
      rw_q     <= 1'b1;
      dout_q   <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      aout_q   <= aout_d;
      w_q      <= w_d;
      rw_q     <= rw_d;
      dout_q   <= dout_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
    end
  end

  assign aout       = aout_q;
  assign w          = w_q;
  assign rw         = rw_q;
  assign dout       = dout_q;
  assign cpu_rdata  = rdata_q;
  assign cpu_rvalid = rvalid_q;
  assign cpu_err    = err_q;

endmodule

// File: tb/tb_j_extreq.sv
// tb_j_extreq: directed scenarios plus randomized traffic against a transaction-level model.
// Builds with or without JEXT_WBUF_EN.
module tb_j_extreq;

  logic        sys_clk = 1'b0;
  logic        resetl;
  logic        cpu_req, cpu_rw;
  logic [2:0]  cpu_w;
  logic [23:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_busy, cpu_rvalid, cpu_err;
  logic [31:0] cpu_rdata;
  logic        mreq, rw;
  logic [2:0]  w;
  logic [23:0] aout;
  logic [31:0] dout;
  logic        ack;
  logic [31:0] din;
  logic [1:0]  dinlatch;

  int n_checks = 0;
  int n_fail   = 0;

  j_extreq dut (
    .sys_clk    (sys_clk),
    .resetl     (resetl),
    .cpu_req    (cpu_req),
    .cpu_rw     (cpu_rw),
    .cpu_w      (cpu_w),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_busy   (cpu_busy),
    .cpu_rdata  (cpu_rdata),
    .cpu_rvalid (cpu_rvalid),
    .cpu_err    (cpu_err),
    .mreq       (mreq),
    .rw         (rw),
    .w          (w),
    .aout       (aout),
    .dout       (dout),
    .ack        (ack),
    .din        (din),
    .dinlatch   (dinlatch)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge sys_clk);
    #1;
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic        rw;
    logic [2:0]  w;
    logic [23:0] addr;
    logic [31:0] data;
  } bus_t;

  bus_t        m_bus;        // fields last presented to the controller
  logic        m_act = 1'b0; // a transaction owns the bus
  logic        m_acc = 1'b0; // ... and the controller has accepted it
  bus_t        wq[$];        // posted writes, head included while in flight
  logic [31:0] m_rdata;
  logic        m_rvalid, m_err;
  logic        m_known = 1'b0;
  logic        m_taken = 1'b0;

  function automatic int unsigned req_size(input logic [2:0] wc);
    if (wc == 3'b000) return 1;
    if (wc == 3'b010) return 2;
    return 4;
  endfunction

  function automatic bus_t mk_req(input logic r, input logic [2:0] wc, input logic [23:0] a,
                                  input logic [31:0] d);
    bus_t        b;
    int unsigned sz;
    sz     = req_size(wc);
    b.rw   = r;
    b.w    = (sz == 1) ? 3'b000 : (sz == 2) ? 3'b010 : 3'b100;
    b.addr = 24'(int'(a) - int'(a % sz));
    b.data = d;
    return b;
  endfunction

  initial begin : model
    logic completing, exp_busy, take;
    bus_t req;
    forever begin
      @(negedge sys_clk);
      completing = m_act && m_acc && ack;
`ifdef JEXT_WBUF_EN
      if (cpu_rw) exp_busy = m_act || (wq.size() != 0);
      else        exp_busy = (wq.size() == 2) && !(completing && !m_bus.rw);
`else
      exp_busy = m_act;
`endif
      if (m_known) begin
        chk("mreq", mreq, m_act && !m_acc);
        chk("busy", cpu_busy, exp_busy);
        chk("aout", aout, m_bus.addr);
        chk("w", w, m_bus.w);
        chk("rw", rw, m_bus.rw);
        chk("dout", dout, m_bus.data);
        chk("rdata", cpu_rdata, m_rdata);
        chk("rvalid", cpu_rvalid, m_rvalid);
        chk("err", cpu_err, m_err);
      end
      take = cpu_req && !exp_busy;
      req  = mk_req(cpu_rw, cpu_w, cpu_addr, cpu_wdata);
      if (!resetl) begin
        m_act    = 1'b0;
        m_acc    = 1'b0;
        wq.delete();
        m_bus    = {1'b1, 3'b000, 24'h0, 32'h0};
        m_rdata  = '0;
        m_rvalid = 1'b0;
        m_err    = 1'b0;
        m_known  = 1'b1;
        m_taken  = 1'b0;
      end else begin
        m_taken  = take;
        m_rvalid = completing && m_bus.rw;
        if (dinlatch[0]) m_rdata[15:0]  = din[15:0];
        if (dinlatch[1]) m_rdata[31:16] = din[31:16];
        if (take && (cpu_addr % req_size(cpu_w)) != 0) m_err = 1'b1;
        if (m_act) begin
          if (!m_acc) m_acc = ack;
          else if (ack) begin
            m_act = 1'b0;
            if (!m_bus.rw) void'(wq.pop_front());
          end
        end else begin
`ifdef JEXT_WBUF_EN
          if (wq.size() != 0) begin
            m_bus = wq[0];
            m_act = 1'b1;
            m_acc = 1'b0;
          end else if (take && cpu_rw) begin
            m_bus = req;
            m_act = 1'b1;
            m_acc = 1'b0;
          end
`else
          if (take) begin
            m_bus = req;
            m_act = 1'b1;
            m_acc = 1'b0;
          end
`endif
        end
`ifdef JEXT_WBUF_EN
        if (take && !cpu_rw) wq.push_back(req);
`endif
      end
    end
  end

  // ---------------- stimulus ----------------
  int   mreq_cnt, rv_cnt, nacc, phase;
  logic took;

  initial begin
    resetl = 1'b0; cpu_req = 1'b0; cpu_rw = 1'b1; cpu_w = 3'b000;
    cpu_addr = '0; cpu_wdata = '0; ack = 1'b0; din = '0; dinlatch = 2'b00;
    repeat (3) cyc();
    resetl = 1'b1;
    #1;
    chk("rst_mreq", mreq, 1'b0);
    chk("rst_rw", rw, 1'b1);
    chk("rst_w", w, 3'b000);
    chk("rst_aout", aout, 24'h0);
    chk("rst_dout", dout, 32'h0);
    chk("rst_rdata", cpu_rdata, 32'h0);
    chk("rst_rvalid", cpu_rvalid, 1'b0);
    chk("rst_err", cpu_err, 1'b0);
    chk("rst_busy", cpu_busy, 1'b0);
    cyc();

    // Long read with ack held off for three ISSUE cycles.
    cpu_req = 1'b1; cpu_rw = 1'b1; cpu_w = 3'b100; cpu_addr = 24'h00F000;
    cyc();
    cpu_req = 1'b0;
    mreq_cnt = 0; rv_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      if (mreq) mreq_cnt++;
      ack      = (i == 3) || (i == 4);
      dinlatch = (i == 4) ? 2'b11 : 2'b00;
      din      = (i == 4) ? 32'hDEADBEEF : 32'h0;
      cyc();
      if (cpu_rvalid) begin
        rv_cnt++;
        chk("long_rd_data", cpu_rdata, 32'hDEADBEEF);
      end
    end
    chk("long_rd_mreq_cycles", mreq_cnt, 4);
    chk("long_rd_rvalid_pulses", rv_cnt, 1);

    // Split capture of the two halves.
    ack = 1'b0; dinlatch = 2'b00;
    cpu_req = 1'b1; cpu_rw = 1'b1; cpu_w = 3'b100; cpu_addr = 24'h000400;
    cyc();
    cpu_req = 1'b0; ack = 1'b1;
    cyc();
    ack = 1'b0; dinlatch = 2'b01; din = 32'hAAAA1234;
    cyc();
    dinlatch = 2'b00; din = 32'h0;
    cyc();
    dinlatch = 2'b10; din = 32'h5678BBBB; ack = 1'b1;
    cyc();
    chk("split_rvalid", cpu_rvalid, 1'b1);
    chk("split_data", cpu_rdata, 32'h56781234);
    ack = 1'b0; dinlatch = 2'b00;
    cyc();
    chk("split_rvalid_once", cpu_rvalid, 1'b0);

    // Completion with the next request already held: one idle cycle between.
    cpu_req = 1'b1; cpu_rw = 1'b1; cpu_w = 3'b100; cpu_addr = 24'h000200; ack = 1'b1;
    cyc();
    cpu_addr = 24'h000300;
    cyc();
    cyc();
    chk("b2b_gap_mreq", mreq, 1'b0);
    #1;
    chk("b2b_gap_busy", cpu_busy, 1'b0);
    cyc();
    chk("b2b_next_mreq", mreq, 1'b1);
    chk("b2b_next_aout", aout, 24'h000300);
    cpu_req = 1'b0;
    repeat (3) cyc();
    ack = 1'b0;

`ifdef JEXT_WBUF_EN
    // Three back-to-back writes with the controller stalled, then a read behind them.
    cpu_req = 1'b1; cpu_rw = 1'b0; cpu_w = 3'b100;
    cpu_addr = 24'h000010; cpu_wdata = 32'h1;
    #1;
    chk("wb_w1_taken", cpu_busy, 1'b0);
    cyc();
    cpu_addr = 24'h000014; cpu_wdata = 32'h2;
    #1;
    chk("wb_w2_taken", cpu_busy, 1'b0);
    cyc();
    cpu_addr = 24'h000018; cpu_wdata = 32'h3;
    #1;
    chk("wb_w3_busy", cpu_busy, 1'b1);
    ack = 1'b1; nacc = 0; phase = 0;
    for (int i = 0; i < 40 && phase < 2; i++) begin
      #1;
      if (mreq && !rw) nacc++;
      took = !cpu_busy;
      if (took && phase == 1) chk("wb_read_after_writes", nacc, 3);
      cyc();
      if (took) begin
        phase++;
        cpu_rw = 1'b1; cpu_addr = 24'h000040;
        if (phase == 2) cpu_req = 1'b0;
      end
    end
    chk("wb_drain_done", phase, 2);
    cpu_req = 1'b0;
    repeat (3) cyc();
    ack = 1'b0;
`endif

    // Misaligned word write: low bit forced to zero, sticky error, no rvalid.
    cpu_req = 1'b1; cpu_rw = 1'b0; cpu_w = 3'b010;
    cpu_addr = 24'h000101; cpu_wdata = 32'hCAFEF00D;
    cyc();
    cpu_req = 1'b0;
    for (int i = 0; i < 4 && !mreq; i++) cyc();
    chk("mis_mreq", mreq, 1'b1);
    chk("mis_aout", aout, 24'h000100);
    chk("mis_w", w, 3'b010);
    chk("mis_err", cpu_err, 1'b1);
    ack = 1'b1;
    cyc();
    cyc();
    chk("wr_no_rvalid", cpu_rvalid, 1'b0);
    ack = 1'b0;
    repeat (2) cyc();
    chk("mis_err_sticky", cpu_err, 1'b1);

    // Reset while waiting for completion abandons the read.
    cpu_req = 1'b1; cpu_rw = 1'b1; cpu_w = 3'b100;
    cpu_addr = 24'h000500; cpu_wdata = 32'h11112222;
    cyc();
    cpu_req = 1'b0; ack = 1'b1;
    cyc();
    resetl = 1'b0; dinlatch = 2'b11; din = 32'h99999999;
    cyc();
    chk("wrst_mreq", mreq, 1'b0);
    chk("wrst_rw", rw, 1'b1);
    chk("wrst_w", w, 3'b000);
    chk("wrst_aout", aout, 24'h0);
    chk("wrst_dout", dout, 32'h0);
    chk("wrst_rdata", cpu_rdata, 32'h0);
    chk("wrst_rvalid", cpu_rvalid, 1'b0);
    chk("wrst_err", cpu_err, 1'b0);
    chk("wrst_busy", cpu_busy, 1'b0);
    resetl = 1'b1; ack = 1'b0; dinlatch = 2'b00;
    cyc();
    chk("wrst_no_rvalid", cpu_rvalid, 1'b0);
    cyc();
    chk("wrst_no_retry", mreq, 1'b0);

    // Randomized traffic; the core holds each request until the model says it was taken.
    for (int n = 0; n < 3000; n++) begin
      if (!cpu_req || m_taken) begin
        cpu_req   = ($urandom % 4) != 0;
        cpu_rw    = 1'($urandom);
        cpu_w     = 3'($urandom);
        cpu_addr  = 24'($urandom);
        cpu_wdata = $urandom;
      end
      ack      = ($urandom % 3) != 0;
      din      = $urandom;
      dinlatch = 2'($urandom);
      resetl   = ($urandom % 250) != 0;
      cyc();
    end
    resetl = 1'b1; cpu_req = 1'b0; ack = 1'b1;
    repeat (10) cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/j_extreq.md
J_EXTREQ -- requirements
Module: j_extreq

Interface
REQ-001 SHALL have ports: sys_clk  in  1  system clock, all state on rising edge; resetl  in  1  reset, synchronous, active-low.
REQ-002 SHALL have core-side ports: cpu_req  in  1  access request; cpu_rw  in  1  1=read, 0=write; cpu_w  in  3  width (3'b000 byte, 3'b010 word, 3'b100 long); cpu_addr  in  24  byte address; cpu_wdata  in  32  store data.
REQ-003 SHALL have core-side outputs: cpu_busy  out  1  request not taken this cycle; cpu_rdata  out  32  load data; cpu_rvalid  out  1  one-cycle load-complete pulse; cpu_err  out  1  sticky misalignment flag.
REQ-004 SHALL have memory-controller ports: mreq  out  1; rw  out  1; w  out  3; aout  out  24; dout  out  32; ack  in  1  controller idle/accept; din  in  32  bus data; dinlatch  in  2  capture strobes (bit0 low half, bit1 high half).
REQ-005 SHALL expose no parameters; widths are fixed as listed.

Function
REQ-006 SHALL implement states IDLE, ISSUE, WAIT.
REQ-007 IDLE: cpu_req=1 loads aout/w/rw/dout from core inputs, enters ISSUE next cycle; cpu_busy=0 in IDLE.
REQ-008 ISSUE: mreq=1, aout/w/rw/dout held stable; acceptance = mreq & ack in the same cycle; on acceptance go to WAIT, mreq=0 next cycle.
REQ-009 WAIT: first cycle with ack=1 at least one cycle after acceptance = completion; go to IDLE.
REQ-010 Reads: on each sys_clk with dinlatch[0]=1, cpu_rdata[15:0]<=din[15:0]; dinlatch[1]=1, cpu_rdata[31:16]<=din[31:16]; both may assert together.
REQ-011 cpu_rvalid SHALL pulse exactly one cycle on read completion; cpu_rdata held until next read capture.
REQ-012 Write completion SHALL produce no cpu_rvalid.
REQ-013 cpu_busy=1 in ISSUE and WAIT (unbuffered build); a cpu_req seen while busy is not taken and must be held by the core.
REQ-014 Misalignment (word with addr[0]=1, long with addr[1:0]!=0): low bits forced to zero on aout, cpu_err set and held until reset; access still performed.
REQ-015 Reserved cpu_w codes SHALL be issued as long.
REQ-016 Completion and a new cpu_req in the same cycle: IDLE entered, new request taken next cycle (one-cycle gap minimum).

Reset
REQ-017 On resetl=0: state IDLE, mreq=0, rw=1, w=0, aout=0, dout=0, cpu_rdata=0, cpu_rvalid=0, cpu_err=0, cpu_busy=0, write buffer empty.
REQ-018 Reset mid-ISSUE/WAIT SHALL abandon the access with no cpu_rvalid and no retry.

Configuration
REQ-019 Macro JEXT_WBUF_EN defined: 2-entry write-posting FIFO; a write is taken when FIFO not full (cpu_busy=0) and retired to the controller in order via ISSUE/WAIT.
REQ-020 With JEXT_WBUF_EN: a read SHALL wait (cpu_busy=1) until the FIFO is empty and no write in flight; FIFO full -> write cpu_busy=1; simultaneous push/pop when full allowed.
REQ-021 Without JEXT_WBUF_EN: no FIFO; behaviour exactly per REQ-013.

Structure
REQ-022 Package j_ext_pkg SHALL hold state encoding and width-code constants (W_BYTE, W_WORD, W_LONG).
REQ-023 Sub-module j_ext_wfifo (2-deep, {addr,w,data}) SHALL exist only under JEXT_WBUF_EN.

Verification
REQ-024 Long read addr 24'h00F000, ack delayed 3 cycles, dinlatch=2'b11 din=32'hDEADBEEF -> mreq high 4 cycles, cpu_rdata=32'hDEADBEEF, one cpu_rvalid pulse.
REQ-025 Split read: dinlatch=01 din[15:0]=16'h1234, later 10 din[31:16]=16'h5678 -> cpu_rdata=32'h56781234 at rvalid.
REQ-026 Word write addr 24'h000101 -> aout=24'h000100, w=3'b010, cpu_err=1 until reset.
REQ-027 Reset asserted in WAIT -> next cycle all outputs at REQ-017 values, no rvalid.
REQ-028 JEXT_WBUF_EN: three back-to-back writes with ack=0 -> first two taken, third busy; read after them waits for all writes complete.
REQ-029 Completion with cpu_req held -> exactly one idle cycle, then mreq for the new access.
